mesh_feed_ctrl: RTL and testbench
=================================

MESH_FEED_CTRL -- requirements
Module: mesh_feed_ctrl

Interface
REQ-001 Parameter MESH_ROWS, default 4: number of mesh rows (lanes) fed.
REQ-002 Parameter IN_W, default 8: width of each a/b/d operand.
REQ-003 Parameter DRAIN_EXTRA, default 2: extra flush cycles after skew drain.
REQ-004 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 Port resetn  input  1: asynchronous, active-low reset.
REQ-006 Port in_valid  input  1: upstream row valid.
REQ-007 Port in_ready  output  1: controller accepts a row this cycle.
REQ-008 Port in_a / in_b / in_d  input  MESH_ROWS x IN_W each: one row of operands, lane-indexed.
REQ-009 Port in_last  input  1: the accepted row is the last row of the current tile.
REQ-010 Port mesh_a / mesh_b / mesh_d  output  MESH_ROWS x IN_W each: skewed operands to the mesh lanes.
REQ-011 Port mesh_valid  output  MESH_ROWS: per-lane valid to the mesh.
REQ-012 Port mesh_prop  output  MESH_ROWS: per-lane propagate control to the mesh.
REQ-013 Port busy  output  1: high in FEED or DRAIN.
REQ-014 Port tile_done  output  1: one-cycle pulse at drain completion.

Function
REQ-015 Handshake: a row SHALL be accepted iff in_valid && in_ready; in_ready SHALL be 1 in IDLE and FEED and 0 in DRAIN.
REQ-016 FSM states: IDLE, FEED, DRAIN.
REQ-017 Transitions: IDLE->FEED on accept without in_last; IDLE->DRAIN or FEED->DRAIN on accept with in_last; DRAIN->IDLE when the drain counter reaches 0.
REQ-018 Drain counter: loaded with MESH_ROWS-1+DRAIN_EXTRA on entry to DRAIN and decremented each DRAIN cycle; tile_done SHALL pulse in the cycle DRAIN exits.
REQ-019 Skew: lane i outputs (a, b, d, valid, prop) SHALL equal the lane-i values accepted 1+i cycles earlier.
REQ-020 Bubbles: a cycle with no accept SHALL inject valid=0 and a/b/d=0 into every lane's skew line.
REQ-021 Propagate: a tile-parity bit SHALL tag every accepted row and SHALL toggle on accept of an in_last row, so consecutive tiles alternate 0/1.
REQ-022 Single-row tile (in_last on the first row) SHALL be legal and SHALL go directly to DRAIN.
REQ-023 busy SHALL be 1 while the state is not IDLE.

Reset
REQ-024 Reset SHALL force IDLE, drain counter 0, parity 0, all skew registers 0, mesh_valid 0, tile_done 0, in_ready 1.
REQ-025 Reset asserted mid-tile SHALL discard all in-flight rows with no tile_done pulse.

Configuration
REQ-026 Macro MESH_FEED_CTRL_PERF_EN: when defined, add outputs perf_busy_cycles (32 bits, counts busy cycles, saturating) and perf_tiles (16 bits, counts tile_done pulses, wrapping), both cleared by reset; when undefined, these ports and counters SHALL be absent.

Structure
REQ-027 The FSM state enum, the MESH_ROWS/IN_W defaults and the drain-count width SHALL live in a shared package mesh_ctrl_pkg.
REQ-028 Sub-module mesh_skew_line (parameterised depth, payload a/b/d/valid/prop) SHALL be instantiated once per lane.

Verification
REQ-029 Four-row tile (in_last on row 3), continuous in_valid -> lane 0 valid in cycles 1-4, lane 3 valid in cycles 4-7, mesh_prop=0, tile_done 3+2 cycles after the last accept, with MESH_ROWS=4 and DRAIN_EXTRA=2.
REQ-030 Two back-to-back tiles -> second tile's mesh_prop=1 on all lanes, in_ready low exactly 5 cycles between the tiles.
REQ-031 Single-row tile, in_a={1,2,3,4} -> mesh_a[3]=4 with mesh_valid[3]=1 exactly 4 cycles after the accept, then tile_done.
REQ-032 in_valid toggling 1,0,1,0 -> bubbles appear in the same positions on every lane, shifted by the lane delay.
REQ-033 resetn low during FEED row 2 -> all mesh_valid 0 and state IDLE immediately; no tile_done pulse.
REQ-034 With MESH_FEED_CTRL_PERF_EN defined, two tiles -> perf_tiles=2 and perf_busy_cycles equal to the count of busy-high cycles.

Source files
------------

// File: rtl/mesh_ctrl_pkg.sv
// Shared types and constants for the mesh feed controller and its skew lines.
package mesh_ctrl_pkg;

   localparam int unsigned MESH_ROWS_DEF = 4;
   localparam int unsigned IN_W_DEF      = 8;
   localparam int unsigned DRAIN_CNT_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FEED  = 2'd1,
      ST_DRAIN = 2'd2
   } feed_state_e;

   // Drain length: skew flush plus extra cycles, never shorter than one cycle.
   function automatic logic [DRAIN_CNT_W-1:0] drain_load(input int unsigned rows,
                                                         input int unsigned extra);
      int unsigned n;
      n = rows - 1 + extra;
      if (n == 0) n = 1;
      return DRAIN_CNT_W'(n);
   endfunction

endpackage

// File: rtl/mesh_skew_line.sv
// Per-lane delay line: DEPTH register stages carrying a/b/d/valid/prop.
// A cycle without push enters as a zero bubble.
module mesh_skew_line #(
   parameter int unsigned DEPTH = 1,
   parameter int unsigned IN_W  = 8
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            push,
   input  logic [IN_W-1:0] a,
   input  logic [IN_W-1:0] b,
   input  logic [IN_W-1:0] d,
   input  logic            prop,
   output logic [IN_W-1:0] skew_a,
   output logic [IN_W-1:0] skew_b,
   output logic [IN_W-1:0] skew_d,
   output logic            skew_valid,
   output logic            skew_prop
);

   logic [DEPTH-1:0][IN_W-1:0] a_sr;
   logic [DEPTH-1:0][IN_W-1:0] b_sr;
   logic [DEPTH-1:0][IN_W-1:0] d_sr;
   logic [DEPTH-1:0]           v_sr;
   logic [DEPTH-1:0]           p_sr;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         a_sr <= '0;
         b_sr <= '0;
         d_sr <= '0;
         v_sr <= '0;
         p_sr <= '0;
      end else begin
         a_sr[0] <= push ? a : '0;
         b_sr[0] <= push ? b : '0;
         d_sr[0] <= push ? d : '0;
         v_sr[0] <= push;
         p_sr[0] <= push ? prop : 1'b0;
         for (int unsigned k = 1; k < DEPTH; k++) begin
            a_sr[k] <= a_sr[k-1];
            b_sr[k] <= b_sr[k-1];
            d_sr[k] <= d_sr[k-1];
            v_sr[k] <= v_sr[k-1];
            p_sr[k] <= p_sr[k-1];
         end
      end
   end

   assign skew_a     = a_sr[DEPTH-1];
   assign skew_b     = b_sr[DEPTH-1];
   assign skew_d     = d_sr[DEPTH-1];
   assign skew_valid = v_sr[DEPTH-1];
   assign skew_prop  = p_sr[DEPTH-1];

endmodule

// File: rtl/mesh_feed_ctrl.sv
// Feeds tiles of rows into a systolic mesh with per-lane skew and drain control.
// Optional perf counters enabled by defining MESH_FEED_CTRL_PERF_EN.
module mesh_feed_ctrl
   import mesh_ctrl_pkg::*;
#(
   parameter int unsigned MESH_ROWS   = MESH_ROWS_DEF,
   parameter int unsigned IN_W        = IN_W_DEF,
   parameter int unsigned DRAIN_EXTRA = 2
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [MESH_ROWS-1:0][IN_W-1:0] in_a,
   input  logic [MESH_ROWS-1:0][IN_W-1:0] in_b,
   input  logic [MESH_ROWS-1:0][IN_W-1:0] in_d,
   input  logic                           in_last,
   output logic [MESH_ROWS-1:0][IN_W-1:0] mesh_a,
   output logic [MESH_ROWS-1:0][IN_W-1:0] mesh_b,
   output logic [MESH_ROWS-1:0][IN_W-1:0] mesh_d,
   output logic [MESH_ROWS-1:0]           mesh_valid,
   output logic [MESH_ROWS-1:0]           mesh_prop,
   output logic                           busy,
   output logic                           tile_done
`ifdef MESH_FEED_CTRL_PERF_EN
   ,
   output logic [31:0]                    perf_busy_cycles,
   output logic [15:0]                    perf_tiles
`endif
);

   localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = drain_load(MESH_ROWS, DRAIN_EXTRA);
   localparam logic [DRAIN_CNT_W-1:0] CNT_ONE    = DRAIN_CNT_W'(1);
   localparam logic [DRAIN_CNT_W-1:0] CNT_TWO    = DRAIN_CNT_W'(2);

   feed_state_e            state;
   logic [DRAIN_CNT_W-1:0] drain_cnt;
   logic                   parity;
   logic                   accept_c;

   assign accept_c = in_valid && in_ready;

   // Control FSM; tile_done is raised for the final DRAIN cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= ST_IDLE;
         drain_cnt <= '0;
         parity    <= 1'b0;
         in_ready  <= 1'b1;
         busy      <= 1'b0;
         tile_done <= 1'b0;
      end else begin
         tile_done <= 1'b0;
         case (state)
            ST_IDLE, ST_FEED: begin
               if (accept_c) begin
                  busy <= 1'b1;
                  if (in_last) begin
                     state     <= ST_DRAIN;
                     drain_cnt <= DRAIN_LOAD;
                     parity    <= ~parity;
                     in_ready  <= 1'b0;
                     tile_done <= (DRAIN_LOAD == CNT_ONE);
                  end else begin
                     state <= ST_FEED;
                  end
               end
            end
            ST_DRAIN: begin
               if (drain_cnt <= CNT_ONE) begin
                  state     <= ST_IDLE;
                  drain_cnt <= '0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end else begin
                  drain_cnt <= drain_cnt - CNT_ONE;
                  tile_done <= (drain_cnt == CNT_TWO);
               end
            end
            default: begin
               state     <= ST_IDLE;
               drain_cnt <= '0;
               in_ready  <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // Lane i is delayed i+1 cycles so the mesh sees a diagonal wavefront.
   for (genvar i = 0; i < MESH_ROWS; i++) begin : g_lane
      mesh_skew_line #(
         .DEPTH (i + 1),
         .IN_W  (IN_W)
      ) u_skew (
         .clk        (clk),
         .resetn     (resetn),
         .push       (accept_c),
         .a          (in_a[i]),
         .b          (in_b[i]),
         .d          (in_d[i]),
         .prop       (parity),
         .skew_a     (mesh_a[i]),
         .skew_b     (mesh_b[i]),
         .skew_d     (mesh_d[i]),
         .skew_valid (mesh_valid[i]),
         .skew_prop  (mesh_prop[i])
      );
   end

`ifdef MESH_FEED_CTRL_PERF_EN
   // Busy-cycle count saturates; tile count wraps.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         perf_busy_cycles <= '0;
         perf_tiles       <= '0;
      end else begin
         if (busy && (perf_busy_cycles != '1)) perf_busy_cycles <= perf_busy_cycles + 32'd1;
         if (tile_done) perf_tiles <= perf_tiles + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mesh_feed_ctrl.sv
// Randomized self-checking bench for mesh_feed_ctrl against a timestamp-based reference.
module tb_mesh_feed_ctrl;

   localparam int unsigned MESH_ROWS   = 4;
   localparam int unsigned IN_W        = 8;
   localparam int unsigned DRAIN_EXTRA = 2;
   localparam int DRAIN_LEN = (MESH_ROWS - 1 + DRAIN_EXTRA == 0) ? 1 : int'(MESH_ROWS - 1 + DRAIN_EXTRA);
   localparam int NCYC = 1500;

   logic clk = 1'b0;
   logic resetn;
   logic in_valid;
   logic in_ready;
   logic in_last;
   logic [MESH_ROWS-1:0][IN_W-1:0] in_a, in_b, in_d;
   logic [MESH_ROWS-1:0][IN_W-1:0] mesh_a, mesh_b, mesh_d;
   logic [MESH_ROWS-1:0]           mesh_valid, mesh_prop;
   logic busy, tile_done;
`ifdef MESH_FEED_CTRL_PERF_EN
   logic [31:0] perf_busy_cycles;
   logic [15:0] perf_tiles;
`endif

   mesh_feed_ctrl #(
      .MESH_ROWS   (MESH_ROWS),
      .IN_W        (IN_W),
      .DRAIN_EXTRA (DRAIN_EXTRA)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_d       (in_d),
      .in_last    (in_last),
      .mesh_a     (mesh_a),
      .mesh_b     (mesh_b),
      .mesh_d     (mesh_d),
      .mesh_valid (mesh_valid),
      .mesh_prop  (mesh_prop),
      .busy       (busy),
      .tile_done  (tile_done)
`ifdef MESH_FEED_CTRL_PERF_EN
      ,
      .perf_busy_cycles (perf_busy_cycles),
      .perf_tiles       (perf_tiles)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = -1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // Reference: every cycle's accepted row (or bubble) is logged; lane i shows entry c-1-i.
   logic                           hist_v [NCYC];
   logic                           hist_p [NCYC];
   logic [MESH_ROWS-1:0][IN_W-1:0] hist_a [NCYC];
   logic [MESH_ROWS-1:0][IN_W-1:0] hist_b [NCYC];
   logic [MESH_ROWS-1:0][IN_W-1:0] hist_d [NCYC];

   bit open, drain_act, parity, draining, exp_busy, exp_done, acc, do_rst;
   int drain_lo, drain_hi, rows_in_tile, tile_len, busy_cnt, tile_cnt;

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_tile_done"}, 32'(tile_done), 32'd0);
      check({tag, "_mesh_valid"}, 32'(mesh_valid), 32'd0);
`ifdef MESH_FEED_CTRL_PERF_EN
      check({tag, "_perf_busy"}, perf_busy_cycles, 32'd0);
      check({tag, "_perf_tiles"}, 32'(perf_tiles), 32'd0);
`endif
   endtask

   initial begin
      for (int k = 0; k < NCYC; k++) begin
         hist_v[k] = 1'b0; hist_p[k] = 1'b0;
         hist_a[k] = '0; hist_b[k] = '0; hist_d[k] = '0;
      end
      open = 0; drain_act = 0; parity = 0; rows_in_tile = 0; tile_len = 4;
      busy_cnt = 0; tile_cnt = 0; drain_lo = 0; drain_hi = 0;
      resetn = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      in_a = '0; in_b = '0; in_d = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("por");
      resetn = 1'b1;

      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         #1;
         cyc = c;
         // Compare outputs of this cycle against the reference.
         draining = drain_act && (c >= drain_lo) && (c <= drain_hi);
         exp_busy = open || draining;
         exp_done = drain_act && (c == drain_hi);
         check("in_ready", 32'(in_ready), 32'(!draining));
         check("busy", 32'(busy), 32'(exp_busy));
         check("tile_done", 32'(tile_done), 32'(exp_done));
         begin
            logic [MESH_ROWS-1:0] ev;
            ev = '0;
            for (int i = 0; i < MESH_ROWS; i++) begin
               int idx;
               logic v;
               logic [IN_W-1:0] ea, eb, ed;
               idx = c - 1 - i;
               v = (idx >= 0) ? hist_v[idx] : 1'b0;
               ea = v ? hist_a[idx][i] : '0;
               eb = v ? hist_b[idx][i] : '0;
               ed = v ? hist_d[idx][i] : '0;
               ev[i] = v;
               check($sformatf("mesh_a%0d", i), 32'(mesh_a[i]), 32'(ea));
               check($sformatf("mesh_b%0d", i), 32'(mesh_b[i]), 32'(eb));
               check($sformatf("mesh_d%0d", i), 32'(mesh_d[i]), 32'(ed));
               if (v) check($sformatf("mesh_prop%0d", i), 32'(mesh_prop[i]), 32'(hist_p[idx]));
            end
            check("mesh_valid", 32'(mesh_valid), 32'(ev));
         end
`ifdef MESH_FEED_CTRL_PERF_EN
         check("perf_busy", perf_busy_cycles, 32'(busy_cnt));
         check("perf_tiles", 32'(perf_tiles), 32'(tile_cnt[15:0]));
`endif
         if (exp_busy) busy_cnt++;
         if (exp_done) tile_cnt++;
         if (!resetn) resetn = 1'b1;

         // Stimulus: directed scenarios first, then random traffic with rare resets.
         do_rst = 1'b0;
         if (c < 18) in_valid = 1'b1;
         else if (c < 22) in_valid = 1'b0;
         else if (c == 22) begin in_valid = 1'b1; tile_len = 1; end
         else if (c < 32) in_valid = 1'b0;
         else if (c < 42) begin tile_len = 4; in_valid = ((c % 2) == 0); end
         else if (c < 46) in_valid = 1'b0;
         else if (c < 48) in_valid = 1'b1;
         else if (c == 48) do_rst = 1'b1;
         else begin
            do_rst   = ($urandom_range(0, 199) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
         end

         if (do_rst) begin
            resetn = 1'b0;
            in_valid = 1'b0;
            #1;
            check_reset_outputs("mid_rst");
            for (int k = 0; k <= c; k++) hist_v[k] = 1'b0;
            open = 0; drain_act = 0; parity = 0; rows_in_tile = 0;
            busy_cnt = 0; tile_cnt = 0;
            tile_len = $urandom_range(1, 6);
            continue;
         end

         for (int i = 0; i < MESH_ROWS; i++) begin
            in_a[i] = (c == 22) ? IN_W'(i + 1) : IN_W'($urandom);
            in_b[i] = IN_W'($urandom);
            in_d[i] = IN_W'($urandom);
         end
         in_last = (rows_in_tile == tile_len - 1);
         acc = in_valid && !draining;
         hist_v[c] = acc;
         hist_p[c] = parity;
         hist_a[c] = in_a;
         hist_b[c] = in_b;
         hist_d[c] = in_d;
         if (acc) begin
            if (in_last) begin
               drain_act = 1; drain_lo = c + 1; drain_hi = c + DRAIN_LEN;
               open = 0; parity = !parity; rows_in_tile = 0;
               if (c >= 48) tile_len = $urandom_range(1, 6);
            end else begin
               open = 1;
               rows_in_tile++;
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
